// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit state encoding
package uart_pkg;

  localparam int   OVERSAMPLE = 16;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - single-byte 8N1 frame engine driven by the 16x sample tick
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic             start,
  input  logic [DBITS-1:0] byte_in,
  output logic             tx,
  output logic             frame_done
);

  localparam int TMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBITS + 1);

  tx_state_e        state_q;
  logic [TW-1:0]    tick_q;
  logic [BW-1:0]    bit_q;
  logic [DBITS-1:0] shift_q;
  logic             tx_q;
  logic             stage_end;

  always_comb begin
    stage_end = 1'b0;
    if (sample_tick) begin
      case (state_q)
        START, DATA: stage_end = (tick_q == TW'(OVERSAMPLE - 1));
        STOP:        stage_end = (tick_q == TW'(SB_TICK - 1));
        default:     stage_end = 1'b0;
      endcase
    end
  end

  // Strobe on the cycle the final stop tick arrives; the owner decides on the same edge
  // whether to chain another byte through start/byte_in.
  assign frame_done = stage_end && (state_q == STOP);
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= byte_in;
            tick_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (stage_end) begin
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else if (sample_tick) begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: begin
          if (stage_end) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BW'(DBITS - 1)) begin
              tx_q    <= IDLE_LEVEL;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= shift_q[1];
            end
          end else if (sample_tick) begin
            tick_q <= tick_q + TW'(1);
          end
        end
        STOP: begin
          if (stage_end) begin
            tick_q <= '0;
            if (start) begin
              shift_q <= byte_in;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else if (sample_tick) begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_tx.sv
// rtl/uart_block_tx.sv - captures a multi-byte block and sends it as back-to-back 8N1 frames
module uart_block_tx
  import uart_pkg::*;
#(
  parameter int DBITS    = 8,
  parameter int NBYTES   = 8,
  parameter int SB_TICK  = 16,
  parameter int CNT_BITS = 4
) (
  input  logic                      clk_100MHz,
  input  logic                      reset_n,
  input  logic                      sample_tick,
  input  logic                      load,
  input  logic [DBITS*NBYTES-1:0]   block_in,
  output logic                      tx,
  output logic                      busy,
  output logic                      block_done,
  output logic [CNT_BITS-1:0]       bytes_left
);

  logic [DBITS*NBYTES-1:0] block_q;
  logic                    busy_q;
  logic                    done_q;
  logic [CNT_BITS-1:0]     left_q;

  logic             accept;
  logic             more;
  logic             frame_done;
  logic             frame_start;
  logic [DBITS-1:0] next_byte;

  // done_q also acts as a one-cycle lockout: a load coinciding with block_done is dropped.
  assign accept      = load && !busy_q && !done_q;
  assign more        = (left_q > CNT_BITS'(1));
  assign frame_start = accept || (frame_done && more);
  // block_q is shifted after every frame, so its second byte is always the next to send.
  assign next_byte   = busy_q ? block_q[DBITS +: DBITS] : block_in[DBITS-1:0];

  uart_frame_tx #(
    .DBITS  (DBITS),
    .SB_TICK(SB_TICK)
  ) u_frame (
    .clk        (clk_100MHz),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .start      (frame_start),
    .byte_in    (next_byte),
    .tx         (tx),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      block_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        block_q <= block_in;
        left_q  <= CNT_BITS'(NBYTES);
        busy_q  <= 1'b1;
      end else if (frame_done && (left_q != '0)) begin
        block_q <= block_q >> DBITS;
        left_q  <= left_q - CNT_BITS'(1);
        if (!more) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign block_done = done_q;
  assign bytes_left = left_q;

endmodule

// File: tb/tb_uart_block_tx.sv
// tb/tb_uart_block_tx.sv - scoreboard bench decoding the serial stream of uart_block_tx
module tb_uart_block_tx;

  localparam int NB    = 8;
  localparam int BOUND = 8000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        load0, load1;
  logic [63:0] blk0, blk1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  logic [3:0]  bl0, bl1;
  logic [1:0]  tx_w, busy_w, done_w;
  bit          tick_rand = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt[2] = '{0, 0};
  int blocks_exp[2] = '{0, 0};
  logic [7:0] exp_q[2][$];

  assign tx_w   = {tx1, tx0};
  assign busy_w = {busy1, busy0};
  assign done_w = {done1, done0};

  uart_block_tx dut (
    .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .load(load0),
    .block_in(blk0), .tx(tx0), .busy(busy0), .block_done(done0), .bytes_left(bl0)
  );

  uart_block_tx #(.SB_TICK(32)) dut32 (
    .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .load(load1),
    .block_in(blk1), .tx(tx1), .busy(busy1), .block_done(done1), .bytes_left(bl1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    int cnt;
    int gap;
    cnt = 0;
    gap = 4;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      cnt++;
      if (cnt >= gap) begin
        sample_tick = 1'b1;
        cnt = 0;
        gap = tick_rand ? int'($urandom_range(1, 4)) : 4;
      end else begin
        sample_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] bl_of(input int ch);
    return (ch == 0) ? bl0 : bl1;
  endfunction

  // Receiver-style monitor: collects per-tick line levels while busy and decodes whole frames.
  task automatic mon(input int ch);
    int ft, sb, n, fidx, bticks;
    logic lvl[176];
    logic [7:0] got;
    bit shape_ok;
    sb = (ch == 0) ? 16 : 32;
    ft = 16 * 9 + sb;
    n = 0; fidx = 0; bticks = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n = 0; fidx = 0; bticks = 0;
      end else begin
        if (done_w[ch]) begin
          done_cnt[ch]++;
          check($sformatf("ch%0d busy low with block_done", ch), busy_w[ch], 0);
          check($sformatf("ch%0d block length ticks", ch), bticks, NB * ft);
          check($sformatf("ch%0d frames per block", ch), fidx, NB);
          n = 0; fidx = 0; bticks = 0;
        end
        if (sample_tick && busy_w[ch]) begin
          if (n == 0)
            check($sformatf("ch%0d bytes_left at frame %0d", ch, fidx), bl_of(ch), NB - fidx);
          lvl[n] = tx_w[ch];
          n++; bticks++;
          if (n == ft) begin
            shape_ok = 1'b1;
            got = '0;
            for (int i = 0; i < ft; i++) begin
              if (i < 16) begin
                if (lvl[i] !== 1'b0) shape_ok = 1'b0;
              end else if (i < 144) begin
                if (lvl[i] !== lvl[16 + 16 * ((i - 16) / 16)]) shape_ok = 1'b0;
                if ((i - 16) % 16 == 8) got[(i - 16) / 16] = lvl[i];
              end else if (lvl[i] !== 1'b1) begin
                shape_ok = 1'b0;
              end
            end
            check($sformatf("ch%0d frame %0d shape", ch, fidx), shape_ok, 1);
            check($sformatf("ch%0d frame %0d expected", ch, fidx), exp_q[ch].size() > 0, 1);
            if (exp_q[ch].size() > 0)
              check($sformatf("ch%0d frame %0d byte", ch, fidx), got, exp_q[ch].pop_front());
            n = 0;
            fidx++;
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic set_load(input int ch, input logic l, input logic [63:0] b);
    if (ch == 0) begin load0 = l; blk0 = b; end
    else begin load1 = l; blk1 = b; end
  endtask

  task automatic do_load(input int ch, input logic [63:0] b, input bit sync);
    if (sync) begin @(posedge clk); #1; end
    set_load(ch, 1'b1, b);
    for (int k = 0; k < NB; k++) exp_q[ch].push_back(b[8*k +: 8]);
    blocks_exp[ch]++;
    @(posedge clk); #1;
    set_load(ch, 1'b0, {$urandom, $urandom});
    check($sformatf("ch%0d tx low after load", ch), tx_w[ch], 0);
    check($sformatf("ch%0d busy after load", ch), busy_w[ch], 1);
    check($sformatf("ch%0d bytes_left after load", ch), bl_of(ch), NB);
  endtask

  task automatic wait_done(input int ch);
    int i;
    for (i = 0; i < BOUND; i++) begin
      @(posedge clk); #1;
      if (done_w[ch]) break;
    end
    check($sformatf("ch%0d block_done within bound", ch), i < BOUND, 1);
  endtask

  task automatic wait_bl(input int ch, input int v);
    int i;
    for (i = 0; i < BOUND; i++) begin
      @(posedge clk); #1;
      if (bl_of(ch) == 4'(v)) break;
    end
    check($sformatf("ch%0d bytes_left reaches %0d", ch, v), i < BOUND, 1);
  endtask

  initial begin
    int idle_bad;
    int t;
    reset_n = 1'b0;
    load0 = 1'b0; load1 = 1'b0; blk0 = '0; blk1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", tx0, 1);
    check("reset busy", busy0, 0);
    check("reset bytes_left", bl0, 0);
    check("reset block_done", done0, 0);
    check("reset tx sb32", tx1, 1);
    reset_n = 1'b1;

    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || bl0 !== 4'd0) idle_bad++;
    end
    check("idle outputs steady", idle_bad, 0);
    check("no block_done while idle", done_cnt[0], 0);

    do_load(0, 64'h0807060504030201, 1);
    wait_done(0);

    do_load(0, 64'hFFFF_FFFF_FFFF_FF00, 1);
    wait_bl(0, 5);
    set_load(0, 1'b1, 64'h0);
    @(posedge clk); #1;
    set_load(0, 1'b0, 64'h0);
    check("load while busy keeps bytes_left", bl0, 5);
    check("load while busy keeps busy", busy0, 1);
    wait_done(0);

    do_load(0, {$urandom, $urandom}, 1);
    wait_bl(0, 6);
    t = 0;
    while (t < 88) begin
      @(negedge clk);
      if (sample_tick) t++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset tx", tx0, 1);
    check("async reset bytes_left", bl0, 0);
    check("async reset busy", busy0, 0);
    exp_q[0].delete();
    blocks_exp[0]--;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no resume after reset busy", busy0, 0);
    check("no resume after reset tx", tx0, 1);
    do_load(0, 64'hA5, 1);
    wait_done(0);

    do_load(0, {$urandom, $urandom}, 1);
    wait_done(0);
    set_load(0, 1'b1, {$urandom, $urandom});
    @(posedge clk); #1;
    check("load in block_done cycle ignored", busy0, 0);
    do_load(0, {$urandom, $urandom}, 0);
    wait_done(0);

    tick_rand = 1'b1;
    repeat (3) begin
      do_load(0, {$urandom, $urandom}, 1);
      wait_done(0);
    end
    tick_rand = 1'b0;

    do_load(1, 64'h55, 1);
    wait_done(1);
    do_load(1, {$urandom, $urandom}, 1);
    wait_done(1);

    repeat (5) @(negedge clk);
    check("ch0 all bytes sent", exp_q[0].size(), 0);
    check("ch1 all bytes sent", exp_q[1].size(), 0);
    check("ch0 block_done count", done_cnt[0], blocks_exp[0]);
    check("ch1 block_done count", done_cnt[1], blocks_exp[1]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
